// File: rtl/hough_peak_scanner_if.sv
// Read port to the Hough accumulator and peak stream towards lane selection.
// The scanner takes the master side; memory and downstream take the slave side.
interface hough_peak_scanner_if #(
    parameter int MSB_PHI  = 7,
    parameter int MSB_R    = 11,
    parameter int MSB_DATA = 15
);
    logic                rd_en;
    logic [MSB_R:0]      rd_r;
    logic [MSB_PHI:0]    rd_phi;
    logic [MSB_DATA:0]   rd_data;

    logic                peak_valid;
    logic                peak_ready;
    logic [MSB_R:0]      peak_r;
    logic [MSB_PHI:0]    peak_phi;
    logic [MSB_DATA:0]   peak_cnt;

    modport master (
        output rd_en, rd_r, rd_phi,
        input  rd_data,
        output peak_valid, peak_r, peak_phi, peak_cnt,
        input  peak_ready
    );

    modport slave (
        input  rd_en, rd_r, rd_phi,
        output rd_data,
        input  peak_valid, peak_r, peak_phi, peak_cnt,
        output peak_ready
    );
endinterface

// File: rtl/hough_peak_scanner.sv
// Raster-scans the Hough accumulator after voting and streams every cell whose
// count reaches the programmed threshold, with its (r, phi) coordinates.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; threshold is latched on start
// SCAN  | issuing reads, phi inner 0..X, r outer 0..Y; stalls on backpressure
// DRAIN | all reads issued; waiting for last compare and empty output/hold
// DONE  | one-cycle done pulse, then back to IDLE
module hough_peak_scanner #(
    parameter int MSB_PHI  = 7,
    parameter int MSB_R    = 11,
    parameter int X        = 179,
    parameter int Y        = 1023,
    parameter int MSB_DATA = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MSB_DATA:0]    threshold,
    hough_peak_scanner_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          peak_total
);
    localparam logic [MSB_R:0]   R_LAST   = Y[MSB_R:0];
    localparam logic [MSB_PHI:0] PHI_LAST = X[MSB_PHI:0];

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t             state;
    logic [MSB_DATA:0]  thr;
    logic [MSB_R:0]     r_cnt;
    logic [MSB_PHI:0]   phi_cnt;

    logic               cmp_valid;
    logic [MSB_R:0]     cmp_r;
    logic [MSB_PHI:0]   cmp_phi;

    logic               out_valid;
    logic [MSB_R:0]     out_r;
    logic [MSB_PHI:0]   out_phi;
    logic [MSB_DATA:0]  out_cnt;

    logic               hold_valid;
    logic [MSB_R:0]     hold_r;
    logic [MSB_PHI:0]   hold_phi;
    logic [MSB_DATA:0]  hold_cnt;

    logic stall, issue, hit, out_free, last_cell;
    logic nxt_out_valid, nxt_hold_valid;

    // Issue/stall decision and the occupancy the buffers will have after this edge.
    // Stalling on a full hold or a blocked output guarantees the read already in
    // flight always has a free slot when it is compared.
    always_comb begin
        stall          = hold_valid || (out_valid && !bus.peak_ready);
        issue          = (state == SCAN) && !stall;
        hit            = cmp_valid && (bus.rd_data >= thr);
        out_free       = !out_valid || bus.peak_ready;
        last_cell      = (r_cnt == R_LAST) && (phi_cnt == PHI_LAST);
        nxt_out_valid  = out_free ? (hold_valid || hit) : 1'b1;
        nxt_hold_valid = out_free ? (hold_valid && hit) : (hold_valid || hit);
    end

    assign bus.rd_en      = issue;
    assign bus.rd_r       = r_cnt;
    assign bus.rd_phi     = phi_cnt;
    assign bus.peak_valid = out_valid;
    assign bus.peak_r     = out_r;
    assign bus.peak_phi   = out_phi;
    assign bus.peak_cnt   = out_cnt;

    // Sequencer: start handling, raster address counters, drain detection, done/busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            thr     <= '0;
            r_cnt   <= '0;
            phi_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        thr     <= threshold;
                        r_cnt   <= '0;
                        phi_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (issue) begin
                        if (last_cell) begin
                            state <= DRAIN;
                        end else if (phi_cnt == PHI_LAST) begin
                            phi_cnt <= '0;
                            r_cnt   <= r_cnt + 1'b1;
                        end else begin
                            phi_cnt <= phi_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!nxt_out_valid && !nxt_hold_valid) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Coordinates ride alongside the one-cycle read latency into the compare stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_valid <= 1'b0;
            cmp_r     <= '0;
            cmp_phi   <= '0;
        end else begin
            cmp_valid <= issue;
            cmp_r     <= r_cnt;
            cmp_phi   <= phi_cnt;
        end
    end

    // Output register plus one-entry hold; hold always drains ahead of a new hit
    // so peaks leave in raster order.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_r      <= '0;
            out_phi    <= '0;
            out_cnt    <= '0;
            hold_valid <= 1'b0;
            hold_r     <= '0;
            hold_phi   <= '0;
            hold_cnt   <= '0;
        end else if (out_free) begin
            if (hold_valid) begin
                out_valid  <= 1'b1;
                out_r      <= hold_r;
                out_phi    <= hold_phi;
                out_cnt    <= hold_cnt;
                hold_valid <= hit;
                if (hit) begin
                    hold_r   <= cmp_r;
                    hold_phi <= cmp_phi;
                    hold_cnt <= bus.rd_data;
                end
            end else begin
                out_valid <= hit;
                if (hit) begin
                    out_r   <= cmp_r;
                    out_phi <= cmp_phi;
                    out_cnt <= bus.rd_data;
                end
            end
        end else if (hit) begin
            hold_valid <= 1'b1;
            hold_r     <= cmp_r;
            hold_phi   <= cmp_phi;
            hold_cnt   <= bus.rd_data;
        end
    end

    // Saturating count of accepted transfers, cleared when a scan starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_total <= '0;
        end else if (state == IDLE && start) begin
            peak_total <= '0;
        end else if (out_valid && bus.peak_ready && peak_total != 16'hFFFF) begin
            peak_total <= peak_total + 16'd1;
        end
    end
endmodule
